// File: rtl/fsm1_rd_responder.sv
// Read responder for the fsm1 sequencer: drives wait-states and returns SEED+addr pattern data.
// Define FSM1_RD_RESPONDER_PARITY_EN to add the registered even-parity output rpar.
module fsm1_rd_responder #(
  parameter int unsigned     DW   = 8,
  parameter int unsigned     AW   = 4,
  parameter int unsigned     WW   = 3,
  parameter logic [DW-1:0]   SEED = DW'(8'hA0)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd,
  input  logic          ds,
  input  logic [WW-1:0] wait_cnt,
  input  logic          err_clr,
  output logic          ws,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic [AW-1:0] addr,
`ifdef FSM1_RD_RESPONDER_PARITY_EN
  output logic          rpar,
`endif
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] cnt_q,   cnt_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q,   err_d;
  logic          err_set;
  logic          load_rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    err_set    = 1'b0;
    load_rdata = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ds) err_set = 1'b1;
        if (rd) begin
          cnt_d = wait_cnt;
          if (wait_cnt != '0) begin
            state_d = WAIT;
          end else begin
            state_d    = READY;
            load_rdata = 1'b1;
          end
        end
      end
      WAIT: begin
        if (ds) err_set = 1'b1;
        cnt_d = cnt_q - WW'(1);
        if (!rd) begin
          state_d = IDLE;
          err_set = 1'b1;
        end else if (cnt_q == WW'(1)) begin
          state_d    = READY;
          load_rdata = 1'b1;
        end
      end
      READY: begin
        // rd held high here is simply the sequencer still waiting for its DONE
        if (ds) begin
          state_d = IDLE;
          addr_d  = addr_q + AW'(1);
        end else if (!rd) begin
          state_d = IDLE;
          err_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    rdata_d = load_rdata ? (SEED + DW'(addr_q)) : rdata_q;

    // A simultaneous set and clear leaves the flag set
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef FSM1_RD_RESPONDER_PARITY_EN
  logic rpar_q, rpar_d;

  always_comb begin
    rpar_d = load_rdata ? (^rdata_d) : rpar_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rpar_q <= 1'b0;
    else        rpar_q <= rpar_d;
  end

  assign rpar = rpar_q;
`endif

  assign ws     = (state_q == WAIT);
  assign rvalid = (state_q == READY);
  assign rdata  = rdata_q;
  assign addr   = addr_q;
  assign err    = err_q;

endmodule

// File: tb/tb_fsm1_rd_responder.sv
// Directed bench for fsm1_rd_responder: reset, zero/3-cycle waits, wrap, aborts, sticky err.
`timescale 1ns/1ps
module tb_fsm1_rd_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rd, ds, err_clr;
  logic [2:0] wait_cnt;
  logic       ws, rvalid, err;
  logic [7:0] rdata;
  logic [3:0] addr;
`ifdef FSM1_RD_RESPONDER_PARITY_EN
  logic       rpar;
  logic [7:0] pexp;
`endif

  int n_tot = 0;
  int n_bad = 0;

  fsm1_rd_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd       (rd),
    .ds       (ds),
    .wait_cnt (wait_cnt),
    .err_clr  (err_clr),
    .ws       (ws),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .addr     (addr),
`ifdef FSM1_RD_RESPONDER_PARITY_EN
    .rpar     (rpar),
`endif
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait read at the current address, ending with a DONE cycle
  task automatic read0(input logic [7:0] exp_data, input logic [3:0] exp_next);
    wait_cnt = 3'd0; rd = 1'b1; ds = 1'b0;
    step();
    chk("r0_ws", ws, 1'b0);
    chk("r0_rvalid", rvalid, 1'b1);
    chk("r0_rdata", rdata, exp_data);
    rd = 1'b0; ds = 1'b1;
    step();
    ds = 1'b0;
    chk("r0_idle", rvalid, 1'b0);
    chk("r0_addr", addr, exp_next);
  endtask

  initial begin
    rst_n = 1'b0; rd = 1'b1; ds = 1'b1; err_clr = 1'b0; wait_cnt = 3'd0;
    repeat (3) step();
    chk("rst_ws", ws, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_addr", addr, 4'd0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_err", err, 1'b0);
    rd = 1'b0; ds = 1'b0;
    rst_n = 1'b1;
    repeat (2) step();
    chk("post_rst_rvalid", rvalid, 1'b0);
    chk("post_rst_err", err, 1'b0);

    read0(8'hA0, 4'd1);
    read0(8'hA1, 4'd2);
    chk("r0_err", err, 1'b0);

    // Wait 3: WAIT for exactly three cycles; a mid-access wait_cnt change is ignored
    wait_cnt = 3'd3; rd = 1'b1;
    step();
    chk("w3_ws1", ws, 1'b1);
    wait_cnt = 3'd7;
    step();
    chk("w3_ws2", ws, 1'b1);
    step();
    chk("w3_ws3", ws, 1'b1);
    chk("w3_notready", rvalid, 1'b0);
    step();
    chk("w3_ws_off", ws, 1'b0);
    chk("w3_rvalid", rvalid, 1'b1);
    chk("w3_rdata", rdata, 8'hA2);
`ifdef FSM1_RD_RESPONDER_PARITY_EN
    pexp = 8'hA2;
    chk("par_a2", rpar, ^pexp);
`endif
    rd = 1'b0; ds = 1'b1;
    step();
    ds = 1'b0;
    chk("w3_addr", addr, 4'd3);
    chk("w3_err", err, 1'b0);

    // Wrap: restart from addr 0, 16 reads return A0..AF, then back to A0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      read0(8'hA0 + 8'(i), 4'(i + 1));
`ifdef FSM1_RD_RESPONDER_PARITY_EN
      if (i == 0) begin
        pexp = 8'hA0;
        chk("par_a0", rpar, ^pexp);
      end
`endif
    end
    chk("wrap_addr", addr, 4'd0);
    read0(8'hA0, 4'd1);

    // Abort in the second WAIT cycle
    wait_cnt = 3'd5; rd = 1'b1;
    step();
    chk("ab_ws1", ws, 1'b1);
    step();
    chk("ab_ws2", ws, 1'b1);
    rd = 1'b0;
    step();
    chk("ab_ws", ws, 1'b0);
    chk("ab_rvalid", rvalid, 1'b0);
    chk("ab_err", err, 1'b1);
    chk("ab_addr", addr, 4'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("clr_err", err, 1'b0);
    ds = 1'b1;
    step();
    chk("idle_ds_err", err, 1'b1);
    chk("idle_ds_rvalid", rvalid, 1'b0);
    chk("idle_ds_addr", addr, 4'd1);
    err_clr = 1'b1;
    step();
    chk("set_wins", err, 1'b1);
    ds = 1'b0;
    step();
    err_clr = 1'b0;
    chk("clr2_err", err, 1'b0);

    // READY with rd and ds both low aborts without incrementing
    wait_cnt = 3'd0; rd = 1'b1;
    step();
    chk("rab_rvalid1", rvalid, 1'b1);
    rd = 1'b0;
    step();
    chk("rab_rvalid0", rvalid, 1'b0);
    chk("rab_err", err, 1'b1);
    chk("rab_addr", addr, 4'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // ds during WAIT only flags err; the wait still runs its course
    wait_cnt = 3'd2; rd = 1'b1;
    step();
    ds = 1'b1;
    step();
    ds = 1'b0;
    chk("wds_err", err, 1'b1);
    chk("wds_ws", ws, 1'b1);
    step();
    chk("wds_rvalid", rvalid, 1'b1);
    chk("wds_rdata", rdata, 8'hA1);

    // Reset mid-access returns everything at once
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", rvalid, 1'b0);
    chk("mid_rst_addr", addr, 4'd0);
    chk("mid_rst_rdata", rdata, 8'h00);
    chk("mid_rst_err", err, 1'b0);
    rd = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
